// File: rtl/reaction_timer.sv
// Reaction-game timer: random WAIT, GO LED, tick-based reaction count with
// false-start detection; the last result is held for the display between rounds.
module reaction_timer #(
  parameter int TICK_DIV  = 100000,
  parameter int MIN_DELAY = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       react_btn,
  output logic [7:0] reaction_time,
  output logic       time_valid,
  output logic       timeout,
  output logic       led_go,
  output logic       false_start,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_GO    = 3'd2,
    S_DONE  = 3'd3,
    S_FALSE = 3'd4
  } state_t;

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
  localparam logic [8:0]     MIN_D      = 9'(MIN_DELAY);

  state_t        r_state;
  state_t        w_next_state;
  logic [2:0]    r_start_sync;
  logic [2:0]    r_react_sync;
  logic          r_start_edge;
  logic          r_react_edge;
  logic [7:0]    r_lfsr;
  logic [PW-1:0] r_presc;
  logic [8:0]    r_delay_cnt;
  logic [7:0]    r_count;
  logic [7:0]    r_reaction_time;
  logic          r_timeout;
  logic          w_tick;
  logic          w_enter_wait;

  assign w_tick       = (r_presc == PRESC_MAX);
  assign w_enter_wait = (w_next_state == S_WAIT) && (r_state != S_WAIT);

  // Two sync flops plus a history flop; the edge pulse itself is registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_sync <= '0;
      r_react_sync <= '0;
      r_start_edge <= 1'b0;
      r_react_edge <= 1'b0;
      r_lfsr       <= 8'hA5;
    end else begin
      r_start_sync <= {r_start_sync[1:0], start_btn};
      r_react_sync <= {r_react_sync[1:0], react_btn};
      r_start_edge <= r_start_sync[1] & ~r_start_sync[2];
      r_react_edge <= r_react_sync[1] & ~r_react_sync[2];
      r_lfsr       <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FALSE: if (r_start_edge) w_next_state = S_WAIT;
      S_WAIT: begin
        if (r_react_edge)                          w_next_state = S_FALSE;
        else if (w_tick && r_delay_cnt == 9'd1)    w_next_state = S_GO;
      end
      S_GO: begin
        if (r_react_edge || (w_tick && r_count == 8'hFF)) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Prescaler restarts on every transition so WAIT and GO start phase-aligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc         <= '0;
      r_delay_cnt     <= '0;
      r_count         <= '0;
      r_reaction_time <= '0;
      r_timeout       <= 1'b0;
    end else begin
      if (w_next_state != r_state) r_presc <= '0;
      else if (w_tick)             r_presc <= '0;
      else                         r_presc <= r_presc + PRESC_ONE;

      if (w_enter_wait) begin
        r_delay_cnt <= MIN_D + {2'b00, r_lfsr[6:0]};
        r_timeout   <= 1'b0;
      end else if (r_state == S_WAIT && w_next_state == S_WAIT && w_tick) begin
        r_delay_cnt <= r_delay_cnt - 9'd1;
      end

      if (r_state == S_WAIT && w_next_state == S_GO)
        r_count <= '0;
      else if (r_state == S_GO && w_next_state == S_GO && w_tick)
        r_count <= r_count + 8'd1;

      // React wins over a coincident tick, so the pre-increment count is kept
      if (r_state == S_GO && w_next_state == S_DONE) begin
        r_reaction_time <= r_react_edge ? r_count : 8'hFF;
        r_timeout       <= ~r_react_edge;
      end else if (r_state == S_WAIT && w_next_state == S_FALSE) begin
        r_reaction_time <= '0;
        r_timeout       <= 1'b0;
      end
    end
  end

  assign reaction_time = r_reaction_time;
  assign timeout       = r_timeout;
  assign state         = r_state;
  assign led_go        = (r_state == S_GO);
  assign time_valid    = (r_state == S_DONE);
  assign false_start   = (r_state == S_FALSE);

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: expected state-entry snapshots are queued
// by the stimulus and checked by a monitor on every observed state change.
module tb_reaction_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn = 1'b0;
  logic       react_btn = 1'b0;
  logic [7:0] reaction_time;
  logic       time_valid, timeout, led_go, false_start;
  logic [2:0] state;

  typedef struct {
    logic [2:0] st;
    logic [7:0] rt;
    int         tol;
    logic       to;
  } exp_t;

  exp_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [2:0] prev_state = 3'd0;
  int         wait_len1, wait_len2;

  reaction_timer #(.TICK_DIV(4), .MIN_DELAY(2)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .react_btn(react_btn),
    .reaction_time(reaction_time), .time_valid(time_valid), .timeout(timeout),
    .led_go(led_go), .false_start(false_start), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rt(input string name, input logic [7:0] act, input logic [7:0] exp, input int tol);
    int d;
    vectors++;
    d = int'(act) - int'(exp);
    if ($isunknown(act) || d > tol || d < -tol) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic expect_tr(input logic [2:0] st, input logic [7:0] rt, input int tol, input logic to);
    exp_t e;
    e.st = st; e.rt = rt; e.tol = tol; e.to = to;
    q.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state !== s) check(name, state, s);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    repeat (4) @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic press_react();
    react_btn = 1'b1;
    repeat (4) @(negedge clk);
    react_btn = 1'b0;
  endtask

  // Identical cycle sequence from reset release to start press each time it runs
  task automatic power_up_round(output int wait_len);
    logic bad;
    int   n;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (reaction_time !== 8'd0 || time_valid !== 1'b0 || timeout !== 1'b0 ||
          led_go !== 1'b0 || false_start !== 1'b0 || state !== 3'd0) bad = 1'b1;
    end
    check("idle_outputs_zero", bad, 1'b0);
    press_react();
    repeat (6) @(negedge clk);
    check("react_in_idle_ignored", state, 3'd0);
    expect_tr(3'd1, 8'd0, 0, 1'b0);
    expect_tr(3'd2, 8'd0, 0, 1'b0);
    press_start();
    wait_state(3'd1, 20, "enter_wait");
    n = 0;
    while (state === 3'd1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    wait_len = n;
    check("wait_reached_go", state, 3'd2);
  endtask

  // Monitor: every state change must match the next queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (state !== prev_state) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_transition: got state %0d, expected state %0d", state, prev_state);
        end else begin
          e = q.pop_front();
          check("tr_state", state, e.st);
          check_rt("tr_reaction_time", reaction_time, e.rt, e.tol);
          check("tr_timeout", timeout, e.to);
          check("tr_led_go", led_go, e.st == 3'd2);
          check("tr_time_valid", time_valid, e.st == 3'd3);
          check("tr_false_start", false_start, e.st == 3'd4);
        end
        prev_state = state;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;

    // Round 1: react 20 cycles after GO -> 5 ticks
    power_up_round(wait_len1);
    check("wait_len_multiple_of_tick", wait_len1 % 4, 0);
    check("wait_len_in_range", (wait_len1 >= 8) && (wait_len1 <= 516), 1);
    expect_tr(3'd3, 8'd5, 1, 1'b0);
    repeat (20) @(negedge clk);
    press_react();
    wait_state(3'd3, 20, "round1_done");
    check_rt("round1_rt", reaction_time, 8'd5, 1);
    check("round1_time_valid", time_valid, 1'b1);

    // Round 2: result holds through WAIT/GO; start pulses in GO are ignored
    expect_tr(3'd1, 8'd5, 1, 1'b0);
    expect_tr(3'd2, 8'd5, 1, 1'b0);
    press_start();
    wait_state(3'd2, 1200, "round2_go");
    @(negedge clk);
    press_start();
    repeat (4) @(negedge clk);
    check("start_in_go_ignored", state, 3'd2);
    check_rt("rt_held_in_go", reaction_time, 8'd5, 1);
    expect_tr(3'd3, 8'd3, 1, 1'b0);
    press_react();
    wait_state(3'd3, 20, "round2_done");
    check_rt("round2_rt", reaction_time, 8'd3, 1);

    // False start, then restart from FALSE and let GO time out
    expect_tr(3'd1, 8'd3, 1, 1'b0);
    expect_tr(3'd4, 8'd0, 0, 1'b0);
    press_start();
    wait_state(3'd1, 20, "fs_wait");
    press_react();
    wait_state(3'd4, 20, "fs_false");
    check("fs_false_start", false_start, 1'b1);
    check("fs_rt_zero", reaction_time, 8'd0);
    expect_tr(3'd1, 8'd0, 0, 1'b0);
    expect_tr(3'd2, 8'd0, 0, 1'b0);
    expect_tr(3'd3, 8'd255, 0, 1'b1);
    press_start();
    wait_state(3'd1, 20, "fs_restart_wait");
    wait_state(3'd3, 2500, "timeout_done");
    check("timeout_flag", timeout, 1'b1);
    check("timeout_rt", reaction_time, 8'd255);

    // New round clears timeout; async reset mid-GO
    expect_tr(3'd1, 8'd255, 0, 1'b0);
    expect_tr(3'd2, 8'd255, 0, 1'b0);
    press_start();
    wait_state(3'd1, 20, "post_to_wait");
    check("timeout_cleared", timeout, 1'b0);
    wait_state(3'd2, 1200, "post_to_go");
    repeat (5) @(negedge clk);
    expect_tr(3'd0, 8'd0, 0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_state", state, 3'd0);
    check("async_reset_rt", reaction_time, 8'd0);
    check("async_reset_led", led_go, 1'b0);

    power_up_round(wait_len2);
    check("lfsr_reseed_wait_len", wait_len2, wait_len1);
    check("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Measures human reaction time for the tt09 reaction game and produces the 8-bit `reaction_time` value consumed by `display_controller`. After a start press it waits a pseudo-random delay, lights the GO LED, and counts elapsed time in fixed ticks until the reaction press. Early presses are flagged as false starts. Results are held stable between rounds so the downstream display shows a steady value.

## Interface
- `TICK_DIV`, default 100000: clock cycles per count tick; 10 ms at 10 MHz. Must be ≥ 2.
- `MIN_DELAY`, default 50: minimum WAIT length in ticks; legal range 1..384.
- `clk` input 1: system clock.
- `reset` input 1: one clock; reset is asynchronous and active-low (0 = reset asserted).
- `start_btn` input 1: start button, asynchronous level, active-high.
- `react_btn` input 1: reaction button, asynchronous level, active-high.
- `reaction_time` output 8: last result in ticks; feeds `display_controller`.
- `time_valid` output 1: high while in DONE.
- `timeout` output 1: high in DONE when the result saturated at 255.
- `led_go` output 1: high while in GO.
- `false_start` output 1: high while in FALSE.
- `state` output 3: IDLE=0, WAIT=1, GO=2, DONE=3, FALSE=4.

## Operation
- Input conditioning: each button passes through a 2-flop synchronizer, then a third flop for edge detection. A rising edge yields a one-cycle `*_edge` pulse.
- LFSR: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1. Seeded 8'hA5 at reset, advances every clock, never reaches 0.
- Prescaler: counts 0..TICK_DIV-1 and emits `tick` on the cycle it equals TICK_DIV-1, then wraps to 0. It is forced to 0 on every state transition.
- `delay_cnt` is 9 bits. `count` is 8 bits.
- IDLE: on `start_edge`, load `delay_cnt = MIN_DELAY + lfsr[6:0]` (sampled that cycle), go to WAIT.
- WAIT:
  - `react_edge` → FALSE; this takes priority over `tick`.
  - On `tick`: if `delay_cnt == 1`, clear `count` and go to GO; otherwise decrement `delay_cnt`.
- GO:
  - `react_edge` → DONE, `reaction_time <= count`.
  - Otherwise, on `tick`: if `count == 255` → DONE, `reaction_time <= 255`, `timeout <= 1`; else `count++`.
  - `react_edge` and `tick` in the same cycle: react wins and the captured value is the pre-increment `count`.
- DONE: holds. `start_edge` → WAIT with a fresh `delay_cnt` load, as from IDLE.
- FALSE: on entry, `reaction_time <= 0` and `timeout <= 0`. `start_edge` → WAIT as from IDLE.
- `timeout` is cleared on any entry to WAIT.
- Ignored events:
  - `start_edge` in WAIT or GO.
  - `react_edge` in IDLE, DONE or FALSE.
- `reaction_time` changes only on entry to DONE or FALSE. It holds through WAIT and GO, so the display keeps the previous result during a round.
- There is no return to IDLE except via reset.

## Timing
- Reset values: state IDLE, all outputs 0, prescaler 0, `count` 0, `delay_cnt` 0, synchronizer flops 0, LFSR 8'hA5.
- Button pin to `*_edge` pulse: 3 clock cycles. The state change is visible on the following edge, i.e. 4 cycles from pin.
- WAIT duration: exactly `delay_cnt` × TICK_DIV cycles, plus 0 cycles of prescaler phase, because the prescaler is cleared on entry.
- GO: `count = k` after k full ticks.
  - A press at pin time t after GO entry yields `floor((t+3)/TICK_DIV)`, saturating at 255.
- All outputs are registered. `led_go`, `time_valid` and `false_start` are derived from registered state and are glitch-free.
- Asynchronous reset mid-round returns to IDLE immediately. No partial result is written.

## Test plan
Sim uses TICK_DIV=4, MIN_DELAY=2.
- Reset, no stimulus:
  - All outputs 0 and `state` = 0 for 100 cycles.
  - Press `react_btn`: `state` stays 0.
- Start press, then react press 5 ticks (20 cycles) after `led_go` rises:
  - `reaction_time` = 5 (±1 for synchronizer phase).
  - `time_valid` = 1, `state` = 3.
- Start press, then react press during WAIT:
  - `state` = 4, `false_start` = 1, `reaction_time` = 0.
  - A second start press returns to WAIT.
- Start press, no react:
  - After 256 ticks in GO: `state` = 3, `reaction_time` = 255, `timeout` = 1.
  - Next start press clears `timeout`.
- From DONE with `reaction_time` = 5, start a new round:
  - `reaction_time` stays 5 through WAIT and GO until the new capture.
  - `start_btn` pulses during GO are ignored.
- Assert `reset` low mid-GO:
  - Outputs clear asynchronously.
  - LFSR restarts at 8'hA5, so the WAIT length after the next start matches the WAIT length of the first round after power-up.
